tlb_flush_seq: RTL

Sequences translation-cache invalidations requested by the privileged-instruction decoder. It accepts the single-cycle fence strobes for sfence.vma, hfence.vvma and hfence.gvma from the Memory stage and latches their operands. It then drives a request/acknowledge handshake to the ITLB and DTLB, holding the pipeline stalled until every TLB has confirmed the flush. It sits between the privileged decoder and the two TLBs, and its stall output feeds the hazard unit.

---
 rtl/tlb_flush_seq_pkg.sv | 18 +
 rtl/tlb_flush_seq_if.sv | 18 +
 rtl/tlb_flush_seq_chan.sv | 26 ++
 rtl/tlb_flush_seq.sv | 56 +++++
 4 files changed

// File: rtl/tlb_flush_seq_pkg.sv
// tlb_flush_seq_pkg: configuration struct, FSM state and flush-kind encodings for tlb_flush_seq
package tlb_flush_seq_pkg;
  typedef struct packed {
    int XLEN;
    int ASID_BITS;
    int VMID_BITS;
    bit H_SUPPORTED;
    bit VIRTMEM_SUPPORTED;
  } cvw_t;
  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, ASID_BITS: 9, VMID_BITS: 14, H_SUPPORTED: 1'b1, VIRTMEM_SUPPORTED: 1'b1};
  typedef enum logic [1:0] {IDLE, REQ, DONE} flushState_t;
  localparam logic [1:0] FLUSH_SFENCE = 2'b00;
  localparam logic [1:0] FLUSH_HVVMA = 2'b01;
  localparam logic [1:0] FLUSH_HGVMA = 2'b10;
  function automatic logic [15:0] idMask(input int bits);
    return 16'((32'd1 << bits) - 32'd1);
  endfunction
endpackage

// File: rtl/tlb_flush_seq_if.sv
// tlb_flush_seq_if: fence strobes from the M stage plus the ITLB/DTLB flush handshake
interface tlb_flush_seq_if #(parameter int XLEN = 64);
  logic sfencevmaM, hfencevvmaM, hfencegvmaM, FlushM;
  logic [XLEN-1:0] FenceVAdrM, FlushVAdr;
  logic [15:0] FenceIdM, FlushId;
  logic Rs1NonZeroM, Rs2NonZeroM;
  logic ITLBFlushAck, DTLBFlushAck, ITLBFlushReq, DTLBFlushReq;
  logic [1:0] FlushKind;
  logic FlushMatchVA, FlushMatchId, FenceStallM, FenceDoneM;
  modport master(
    input sfencevmaM, hfencevvmaM, hfencegvmaM, FlushM, FenceVAdrM, FenceIdM, Rs1NonZeroM, Rs2NonZeroM, ITLBFlushAck, DTLBFlushAck,
    output ITLBFlushReq, DTLBFlushReq, FlushVAdr, FlushId, FlushKind, FlushMatchVA, FlushMatchId, FenceStallM, FenceDoneM
  );
  modport slave(
    output sfencevmaM, hfencevvmaM, hfencegvmaM, FlushM, FenceVAdrM, FenceIdM, Rs1NonZeroM, Rs2NonZeroM, ITLBFlushAck, DTLBFlushAck,
    input ITLBFlushReq, DTLBFlushReq, FlushVAdr, FlushId, FlushKind, FlushMatchVA, FlushMatchId, FenceStallM, FenceDoneM
  );
endinterface

// File: rtl/tlb_flush_seq_chan.sv
// tlb_flush_chan: one TLB's level-held flush request and its completion flag
module tlb_flush_chan (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  input  logic ack,
  output logic req,
  output logic done
);
  logic acked;
  // done counts the ack being sampled this edge so the sequencer can advance without a bubble
  assign done = acked | (req & ack);
  // raise req while enabled and not yet acked; an ack with req low is ignored
  always_ff @(posedge clk)
    if (!reset) begin
      req <= 1'b0;
      acked <= 1'b0;
    end else if (start) begin
      req <= en;
      acked <= 1'b0;
    end else if (req & ack) begin
      req <= 1'b0;
      acked <= 1'b1;
    end else if (en & ~acked) req <= 1'b1;
endmodule

// File: rtl/tlb_flush_seq.sv
// tlb_flush_seq: sequences ITLB/DTLB flushes for sfence.vma/hfence.*; define TLBFLUSH_SERIAL_EN to flush ITLB then DTLB
module tlb_flush_seq import tlb_flush_seq_pkg::*; #(parameter cvw_t P = CVW_DEFAULT) (
  input logic clk,
  input logic reset,
  tlb_flush_seq_if.master bus
);
  flushState_t state;
  logic gvma, vvma, accept, inReq, iEn, dEn, iReq, dReq, iDone, dDone, doneQ, matchVaQ, matchIdQ;
  logic [1:0] kind, kindQ;
  logic [P.XLEN-1:0] vAdrQ;
  logic [15:0] idQ;
  assign gvma = bus.hfencegvmaM & P.H_SUPPORTED;
  assign vvma = bus.hfencevvmaM & P.H_SUPPORTED;
  assign accept = (state == IDLE) & P.VIRTMEM_SUPPORTED & (bus.sfencevmaM | vvma | gvma) & ~bus.FlushM;
  assign kind = gvma ? FLUSH_HGVMA : vvma ? FLUSH_HVVMA : FLUSH_SFENCE;
  assign inReq = state == REQ;
  assign iEn = accept | inReq;
`ifdef TLBFLUSH_SERIAL_EN
  assign dEn = inReq & iDone;
`else
  assign dEn = iEn;
`endif
  tlb_flush_chan uItlb (.clk(clk), .reset(reset), .start(accept), .en(iEn), .ack(bus.ITLBFlushAck), .req(iReq), .done(iDone));
  tlb_flush_chan uDtlb (.clk(clk), .reset(reset), .start(accept), .en(dEn), .ack(bus.DTLBFlushAck), .req(dReq), .done(dDone));
  // accept and latch operands in IDLE, wait for both TLBs in REQ, pulse completion in DONE
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      doneQ <= 1'b0;
      vAdrQ <= '0;
      idQ <= '0;
      kindQ <= FLUSH_SFENCE;
      matchVaQ <= 1'b0;
      matchIdQ <= 1'b0;
    end else begin
      doneQ <= inReq & iDone & dDone;
      if (accept) begin
        state <= REQ;
        vAdrQ <= bus.FenceVAdrM;
        idQ <= bus.FenceIdM & idMask(kind == FLUSH_HGVMA ? P.VMID_BITS : P.ASID_BITS);
        kindQ <= kind;
        matchVaQ <= bus.Rs1NonZeroM;
        matchIdQ <= bus.Rs2NonZeroM;
      end else if (inReq & iDone & dDone) state <= DONE;
      else if (state == DONE) state <= IDLE;
    end
  assign bus.ITLBFlushReq = iReq;
  assign bus.DTLBFlushReq = dReq;
  assign bus.FlushVAdr = vAdrQ;
  assign bus.FlushId = idQ;
  assign bus.FlushKind = kindQ;
  assign bus.FlushMatchVA = matchVaQ;
  assign bus.FlushMatchId = matchIdQ;
  assign bus.FenceStallM = accept | inReq;
  assign bus.FenceDoneM = doneQ;
endmodule
